// File: rtl/arilla_bus_pkg.sv
// Shared definitions for the arilla bus arbiter.
// - Default bus widths used as parameter defaults by the arbiter.
// - Arbiter FSM state type.
// - rr_next(): round-robin search helper returning a found flag and index.
package arilla_bus_pkg;

  // Default slave-side widths.
  localparam int unsigned DefaultWordAddressWidth = 30;
  localparam int unsigned DefaultDataWidth        = 32;
  localparam int unsigned DefaultBytesPerWord     = 4;

  // Upper bound on requesters and matching index width.
  localparam int unsigned MaxMasters  = 8;
  localparam int unsigned MaxIdxWidth = 3;

  // Width of the fairness counter; covers quanta up to 255.
  localparam int unsigned CountWidth = 8;

  typedef enum logic [0:0] {
    StIdle,
    StGranted
  } arb_state_e;

  typedef struct packed {
    logic                   found;
    logic [MaxIdxWidth-1:0] idx;
  } rr_result_t;

  // Search req at last+1, last+2, ... modulo num and return the first hit.
  // last itself is visited last, so a requester that just held the bus
  // only wins again when nobody else is asking.
  function automatic rr_result_t rr_next(input logic [MaxMasters-1:0]  req,
                                         input logic [MaxIdxWidth-1:0] last,
                                         input int unsigned            num);
    rr_result_t  res;
    int unsigned j;
    res = '0;
    for (int unsigned k = 1; k <= MaxMasters; k++) begin
      if (!res.found && k <= num) begin
        j = (32'(last) + k) % num;
        if (req[j[MaxIdxWidth-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[MaxIdxWidth-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arilla_bus_arbiter_rr_picker.sv
// Combinational round-robin priority search.
// Ports:
//   req_i   - request vector, one bit per master
//   last_i  - index searched last; the search starts at last_i+1 and wraps
//   valid_o - at least one request was found
//   idx_o   - index of the first requester found
module arilla_bus_arbiter_rr_picker
  import arilla_bus_pkg::*;
#(
  parameter int unsigned NumMasters = 3
) (
  input  logic [NumMasters-1:0]         req_i,
  input  logic [$clog2(NumMasters)-1:0] last_i,
  output logic                          valid_o,
  output logic [$clog2(NumMasters)-1:0] idx_o
);

  localparam int unsigned IdxWidth = $clog2(NumMasters);

  rr_result_t res;

  always_comb begin
    res     = rr_next(MaxMasters'(req_i), MaxIdxWidth'(last_i), NumMasters);
    valid_o = res.found;
    idx_o   = IdxWidth'(res.idx);
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter sharing one arilla bus slave port between NumMasters
// requesters, with per-master lock and a fairness quantum.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   m_req_i          - master i wants the bus
//   m_lock_i         - master i may hold the grant beyond the quantum
//   m_available_o    - registered one-hot-or-zero grant
//   m_address_i, m_byte_enable_i, m_data_ctp_i, m_read_i, m_write_i
//                    - flattened master request fields, slice i = master i
//   m_data_ptc_o     - broadcast read data (straight from the slave)
//   m_rvalid_o       - read data valid for master i this cycle
//   s_*_o            - request of the granted master towards the slave
//   s_data_ptc_i     - slave read data, valid the cycle after s_read_o
module arilla_bus_arbiter
  import arilla_bus_pkg::*;
#(
  parameter int unsigned NumMasters       = 3,
  parameter int unsigned WordAddressWidth = DefaultWordAddressWidth,
  parameter int unsigned DataWidth        = DefaultDataWidth,
  parameter int unsigned BytesPerWord     = DefaultBytesPerWord,
  parameter int unsigned Quantum          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NumMasters-1:0]                m_req_i,
  input  logic [NumMasters-1:0]                m_lock_i,
  output logic [NumMasters-1:0]                m_available_o,
  input  logic [NumMasters*WordAddressWidth-1:0] m_address_i,
  input  logic [NumMasters*BytesPerWord-1:0]   m_byte_enable_i,
  input  logic [NumMasters*DataWidth-1:0]      m_data_ctp_i,
  input  logic [NumMasters-1:0]                m_read_i,
  input  logic [NumMasters-1:0]                m_write_i,
  output logic [DataWidth-1:0]                 m_data_ptc_o,
  output logic [NumMasters-1:0]                m_rvalid_o,
  output logic [WordAddressWidth-1:0]          s_address_o,
  output logic [BytesPerWord-1:0]              s_byte_enable_o,
  output logic [DataWidth-1:0]                 s_data_ctp_o,
  output logic                                 s_read_o,
  output logic                                 s_write_o,
  input  logic [DataWidth-1:0]                 s_data_ptc_i
);

  localparam int unsigned IdxWidth = $clog2(NumMasters);
  localparam logic [CountWidth-1:0] QuantumLast = CountWidth'(Quantum - 1);
  localparam logic [NumMasters-1:0] OneBit = NumMasters'(1);

  arb_state_e state_q, state_d;

  logic [IdxWidth-1:0]   owner_q, owner_d;
  logic [IdxWidth-1:0]   rr_last_q, rr_last_d;
  logic [IdxWidth-1:0]   rd_owner_q;
  logic [CountWidth-1:0] count_q, count_d;
  logic [NumMasters-1:0] avail_q, avail_d;
  logic                  rd_pending_q;

  logic                  grant_valid;
  logic                  competitor;
  logic [NumMasters-1:0] owner_onehot;
  logic [IdxWidth-1:0]   pick_last;
  logic                  pick_valid;
  logic [IdxWidth-1:0]   pick_idx;

  assign grant_valid  = (state_q == StGranted);
  assign owner_onehot = OneBit << owner_q;
  assign competitor   = |(m_req_i & ~owner_onehot);

  // From idle the search resumes after the last owner; while granted it
  // starts after the current owner. Either way the owner itself is
  // searched last, so one picker serves both transitions.
  assign pick_last = grant_valid ? owner_q : rr_last_q;

  arilla_bus_arbiter_rr_picker #(
    .NumMasters (NumMasters)
  ) u_rr_picker (
    .req_i   (m_req_i),
    .last_i  (pick_last),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Grant transition logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    count_d   = count_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGranted;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      StGranted: begin
        if (!m_req_i[owner_q]) begin
          // Owner released the bus.
          rr_last_d = owner_q;
          count_d   = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end else if (competitor) begin
          if (count_q == QuantumLast) begin
            // Quantum used up: rotate unless the owner is in a locked
            // sequence, in which case the counter stays saturated.
            if (!m_lock_i[owner_q]) begin
              rr_last_d = owner_q;
              owner_d   = pick_idx;
              count_d   = '0;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    avail_d = (state_d == StGranted) ? (OneBit << owner_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      count_q      <= '0;
      rr_last_q    <= IdxWidth'(NumMasters - 1);
      avail_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
      rr_last_q    <= rr_last_d;
      avail_q      <= avail_d;
      // Remember who issued the read so the late data reaches it even if
      // the grant moves at this edge.
      rd_pending_q <= s_read_o;
      rd_owner_q   <= owner_q;
    end
  end

  assign m_available_o = avail_q;

  // Slave side: owner's slice while granted, all zero otherwise.
  always_comb begin
    s_address_o     = '0;
    s_byte_enable_o = '0;
    s_data_ctp_o    = '0;
    s_read_o        = 1'b0;
    s_write_o       = 1'b0;
    if (grant_valid) begin
      s_address_o     = m_address_i[32'(owner_q)*WordAddressWidth +: WordAddressWidth];
      s_byte_enable_o = m_byte_enable_i[32'(owner_q)*BytesPerWord +: BytesPerWord];
      s_data_ctp_o    = m_data_ctp_i[32'(owner_q)*DataWidth +: DataWidth];
      s_read_o        = m_read_i[owner_q];
      s_write_o       = m_write_i[owner_q];
    end
  end

  assign m_data_ptc_o = s_data_ptc_i;
  assign m_rvalid_o   = rd_pending_q ? (OneBit << rd_owner_q) : '0;

  a_avail_onehot0: assert property (@(posedge clk) $onehot0(m_available_o));

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
module tb_arilla_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int Q  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     m_req, m_lock, m_read, m_write;
  logic [N-1:0]     m_available, m_rvalid;
  logic [N*AW-1:0]  m_address;
  logic [N*BW-1:0]  m_byte_enable;
  logic [N*DW-1:0]  m_data_ctp;
  logic [DW-1:0]    m_data_ptc;
  logic [AW-1:0]    s_address;
  logic [BW-1:0]    s_byte_enable;
  logic [DW-1:0]    s_data_ctp;
  logic             s_read, s_write;
  logic [DW-1:0]    s_data_ptc;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  arilla_bus_arbiter #(
    .NumMasters       (N),
    .WordAddressWidth (AW),
    .DataWidth        (DW),
    .BytesPerWord     (BW),
    .Quantum          (Q)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_req_i         (m_req),
    .m_lock_i        (m_lock),
    .m_available_o   (m_available),
    .m_address_i     (m_address),
    .m_byte_enable_i (m_byte_enable),
    .m_data_ctp_i    (m_data_ctp),
    .m_read_i        (m_read),
    .m_write_i       (m_write),
    .m_data_ptc_o    (m_data_ptc),
    .m_rvalid_o      (m_rvalid),
    .s_address_o     (s_address),
    .s_byte_enable_o (s_byte_enable),
    .s_data_ctp_o    (s_data_ctp),
    .s_read_o        (s_read),
    .s_write_o       (s_write),
    .s_data_ptc_i    (s_data_ptc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // own = -1 means nobody holds the bus; held counts contested cycles.
  int own, held, last, rdo;
  bit rdp;
  bit rd_now;
  int rdo_now;
  logic [N-1:0] others;

  function automatic int search(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      if (r[(after + k) % N]) return (after + k) % N;
    end
    return -1;
  endfunction

  initial begin
    own = -1; held = 0; last = N - 1; rdp = 1'b0; rdo = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      own = -1; held = 0; last = N - 1; rdp = 1'b0; rdo = 0;
    end else begin
      rd_now  = (own >= 0) && m_read[own];
      rdo_now = (own >= 0) ? own : 0;
      if (own < 0) begin
        own  = search(m_req, last);
        held = 0;
      end else if (!m_req[own]) begin
        last = own;
        own  = search(m_req, own);
        held = 0;
      end else begin
        others      = m_req;
        others[own] = 1'b0;
        if (others == '0) begin
          held = 0;
        end else if (held == Q - 1) begin
          if (!m_lock[own]) begin
            last = own;
            own  = search(m_req, own);
            held = 0;
          end
        end else begin
          held++;
        end
      end
      rdp = rd_now;
      rdo = rdo_now;
    end
  end

  // Every-cycle comparison against the model.
  logic [N-1:0]  e_av, e_rv;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [DW-1:0] e_dat;
  logic          e_rd, e_wr;

  always @(negedge clk) begin
    if (check_en) begin
      e_av = '0; e_addr = '0; e_be = '0; e_dat = '0; e_rd = 1'b0; e_wr = 1'b0;
      if (own >= 0) begin
        e_av[own] = 1'b1;
        e_addr    = m_address[own*AW +: AW];
        e_be      = m_byte_enable[own*BW +: BW];
        e_dat     = m_data_ctp[own*DW +: DW];
        e_rd      = m_read[own];
        e_wr      = m_write[own];
      end
      e_rv = '0;
      if (rdp) e_rv[rdo] = 1'b1;
      chk("m_available", m_available, e_av);
      chk("s_address", s_address, e_addr);
      chk("s_byte_enable", s_byte_enable, e_be);
      chk("s_data_ctp", s_data_ctp, e_dat);
      chk("s_read", s_read, e_rd);
      chk("s_write", s_write, e_wr);
      chk("m_rvalid", m_rvalid, e_rv);
      chk("m_data_ptc", m_data_ptc, s_data_ptc);
      chk("avail_onehot0", ($countones(m_available) <= 1), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]     = AW'($urandom);
      m_byte_enable[i*BW +: BW] = BW'($urandom);
      m_data_ctp[i*DW +: DW]    = $urandom;
    end
    s_data_ptc = $urandom;
  endtask

  bit got;

  initial begin
    rst_n = 1'b0;
    m_req = '0; m_lock = '0; m_read = '0; m_write = '0;
    randomize_fields();

    // Reset: no grant and no slave access even with requests present.
    @(posedge clk);
    check_en = 1'b1;
    #2;
    m_req  = 3'b010;
    m_read = 3'b111;
    @(negedge clk);
    chk("rst_s_read", s_read, 0);
    tick();
    @(negedge clk);
    chk("rst_s_read2", s_read, 0);
    chk("rst_avail", m_available, 0);
    tick(); rst_n = 1'b1; m_req = '0; m_read = '0;
    @(negedge clk);
    chk("post_rst_avail", m_available, 0);
    chk("post_rst_rvalid", m_rvalid, 0);

    // Request latency: grant visible one edge after the request.
    tick(); m_req = 3'b010;
    @(negedge clk);
    chk("no_early_grant", m_available, 3'b000);
    tick();
    @(negedge clk);
    chk("grant_next_cycle", m_available, 3'b010);
    tick(); m_req = '0;
    tick();
    @(negedge clk);
    chk("release_idle", m_available, 3'b000);

    // Full contention: 0,1,2,0 for exactly Q cycles each.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; m_req = 3'b111;
    @(negedge clk);
    chk("rot_pre", m_available, 3'b000);
    for (int i = 0; i < 4 * Q; i++) begin
      @(negedge clk);
      chk("rotation", m_available, 3'b001 << ((i / Q) % 3));
    end

    // Lock keeps master 0 past the quantum; dropping it hands over quickly.
    tick(); rst_n = 1'b0; m_req = '0;
    tick(); rst_n = 1'b1; m_req = 3'b011; m_lock = 3'b001;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("lock_hold", m_available, 3'b001);
    end
    tick(); m_lock = '0;
    got = 1'b0;
    for (int k = 0; k < Q && !got; k++) begin
      @(negedge clk);
      if (m_available == 3'b010) got = 1'b1;
    end
    chk("lock_release_within_q", got, 1);

    // Read in the owner's final cycle completes to it after the grant moves.
    tick(); rst_n = 1'b0; m_req = '0; m_lock = '0;
    tick(); rst_n = 1'b1; m_req = 3'b110;
    tick();
    @(negedge clk);
    chk("rd_owner1", m_available, 3'b010);
    tick();
    m_req = 3'b100; m_read = 3'b010;
    m_address[1*AW +: AW] = AW'(32'h10);
    @(negedge clk);
    chk("rd_s_read", s_read, 1);
    chk("rd_s_address", s_address, 32'h10);
    tick(); m_read = '0; s_data_ptc = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rvalid", m_rvalid, 3'b010);
    chk("rd_data", m_data_ptc, 32'hDEADBEEF);
    chk("rd_new_owner", m_available, 3'b100);

    // Write from the owner; the ungranted master's write is ignored.
    tick(); rst_n = 1'b0; m_req = '0;
    tick(); rst_n = 1'b1; m_req = 3'b101;
    tick();
    m_write = 3'b101;
    m_data_ctp[0*DW +: DW]    = 32'hA5A5A5A5;
    m_byte_enable[0*BW +: BW] = 4'b0011;
    m_data_ctp[2*DW +: DW]    = 32'h12345678;
    m_byte_enable[2*BW +: BW] = 4'b1111;
    @(negedge clk);
    chk("wr_s_write", s_write, 1);
    chk("wr_data", s_data_ctp, 32'hA5A5A5A5);
    chk("wr_be", s_byte_enable, 4'b0011);
    tick(); m_write = 3'b100;
    @(negedge clk);
    chk("wr_ignored", s_write, 0);

    // Reset sampled at the edge after a read: no completion pulse.
    tick(); m_write = '0; m_read = 3'b001; rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_s_read", s_read, 1);
    tick(); m_read = '0; rst_n = 1'b1;
    @(negedge clk);
    chk("rstrd_rvalid", m_rvalid, 0);
    chk("rstrd_avail", m_available, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) m_req = N'($urandom);
      if ($urandom_range(0, 7) == 0) m_lock = N'($urandom) & N'($urandom);
      m_read  = N'($urandom);
      m_write = N'($urandom);
      randomize_fields();
    end

    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
